status_led_ctl: RTL and testbench
=================================

// Module: status_led_ctl
// PURPOSE
//  Parametrised multi-channel status-LED driver. Replaces ad-hoc LED assigns and the single heartbeat counter in board tops.
//  Each channel is runtime-selectable: off, on, level-follow, pulse-stretched activity, heartbeat or N-flash blink code.
//  Sits in the lb_clk domain. Mode registers are written from the local-bus decoder.
// PARAMETERS
//  N_CH          4     number of LED channels (1..16)
//  PRESC_W       20    prescaler width; tick period = 2**PRESC_W clk cycles
//  HB_SEL        6     heartbeat = tick_cnt[HB_SEL] (0..7)
//  STRETCH_TICKS 8     activity hold time in ticks (1..255)
//  BLINK_TICKS   16    blink on/off phase length in ticks (1..255)
//  ACTIVE_LOW    0     1 = invert all led outputs
//  DEFAULT_MODE  3'd4  mode loaded into every channel at reset
// PORTS
//  clk        in   1        single clock (lb_clk)
//  reset      in   1        asynchronous, active-high
//  status_in  in   N_CH     level inputs, clk domain
//  event_in   in   N_CH     activity strobes, clk domain, any width
//  cfg_we     in   1        write strobe for mode register
//  cfg_addr   in   4        channel index
//  cfg_wdata  in   8        [2:0] mode, [6:3] blink count, [7] reserved
//  cfg_rdata  out  8        registered readback of addressed channel
//  tick       out  1        one-cycle prescaler tick
//  led        out  N_CH     LED drive, registered
// BEHAVIOUR
//  Reset: async. All counters are 0. Modes = DEFAULT_MODE, blink counts = 0. cfg_rdata = 0, tick = 0.
//   led = off level (ACTIVE_LOW ? 1 : 0). Deassertion takes effect on the next clk edge.
//  Prescaler: free-running PRESC_W-bit counter. tick = 1 for exactly the cycle in which the counter is all-ones.
//   tick_cnt (8 bit) increments on tick and wraps 255->0.
//  Modes: 0 OFF, 1 ON, 2 LEVEL, 3 ACTIVITY, 4 HEARTBEAT, 5 BLINK. Values 6 and 7 behave as OFF.
//  All led bits are registered. The output reflects state/inputs with 1-cycle latency, then ACTIVE_LOW inversion is applied.
//  LEVEL: led <= status_in[i].
//  ACTIVITY: a per-channel 8-bit stretch counter.
//   event_in=1 loads STRETCH_TICKS. Otherwise, on tick with cnt!=0, cnt decrements.
//   Event and tick in the same cycle: load wins. led <= (cnt!=0 || event_in).
//   A held event keeps the LED lit. A retrigger restarts the full hold time.
//  HEARTBEAT: led <= tick_cnt[HB_SEL]; all heartbeat channels are phase-aligned.
//  BLINK FSM per channel: states ON, OFF, GAP, each with a phase counter in ticks.
//   ON lasts BLINK_TICKS ticks, then go to OFF and increment flash count.
//   OFF lasts BLINK_TICKS ticks. If flash count < N, go to ON. Else go to GAP.
//   GAP lasts 4*BLINK_TICKS ticks, then clear flash count and go to ON.
//   Phase boundaries are counted in ticks only. The first phase after (re)start may be up to 1 tick short.
//   N = 0: LED off and FSM held in GAP.
//   led <= (state==ON).
//  cfg write to a valid channel replaces mode and count.
//   It clears that channel's stretch counter and restarts blink at ON with count 0.
//   Writing identical data also restarts.
//  cfg_addr >= N_CH: writes are ignored and cfg_rdata <= 0.
//  cfg_rdata <= {1'b0, count, mode} of cfg_addr every cycle (1-cycle latency).
//   Write and read of the same address in one cycle: old value is returned.
//  Non-active channels keep running their prescaler-derived state but are masked at the output.
// TESTING (PRESC_W=2, STRETCH_TICKS=3, BLINK_TICKS=2, HB_SEL=1, N_CH=3)
//  Reset -> led=3'b000, tick=0; read addr 0..2 -> 8'h04; async reset mid-run -> led off same cycle, no clk needed.
//  Mode 3 on ch1, 1-cycle event at cycle t -> led[1]=1 from t+1, clears after 3rd tick following t.
//   Event again 1 tick before expiry -> holds 3 more ticks.
//  Mode 5, count 3 on ch0 -> three high pulses of 8 cycles, each followed by 8 low cycles.
//   Then 32 low cycles (gap), then the pattern repeats. Count 0 -> led[0] stays 0.
//  Mode 4 on ch2 -> led[2] toggles every 8 cycles.
//   Mode 2 -> led tracks status_in with 1-cycle lag. Modes 0/1/6/7 -> constant 0/1/0/0.
//  Write cfg_addr=3 (out of range) -> no channel changes, cfg_rdata=0.
//   Simultaneous write+read same addr -> old value, new value on the next cycle.
//  ACTIVE_LOW=1 rerun of the reset and heartbeat tests -> all led levels inverted.

Source files
------------

// File: rtl/status_led_ctl.sv
// ---------------------------------------------------------------------------
// status_led_ctl
//
// Multi-channel status-LED driver for board tops. Each channel carries a
// runtime-selectable mode: off, on, level-follow, pulse-stretched activity,
// heartbeat or an N-flash blink code. A shared prescaler produces a slow
// tick from which the activity hold time, the heartbeat and the blink
// phases are derived. Mode registers are written from the local-bus decoder.
//
// Ports
//   clk        in   1      single clock (lb_clk)
//   reset      in   1      asynchronous, active-high
//   status_in  in   N_CH   level inputs (LEVEL mode)
//   event_in   in   N_CH   activity strobes (ACTIVITY mode), any width
//   cfg_we     in   1      mode register write strobe
//   cfg_addr   in   4      channel index for write and readback
//   cfg_wdata  in   8      [2:0] mode, [6:3] blink count, [7] reserved
//   cfg_rdata  out  8      registered readback {1'b0, count, mode}
//   tick       out  1      one-cycle prescaler tick
//   led        out  N_CH   registered LED drive, ACTIVE_LOW applied
// ---------------------------------------------------------------------------
module status_led_ctl #(
    parameter int         N_CH          = 4,
    parameter int         PRESC_W       = 20,
    parameter int         HB_SEL        = 6,
    parameter int         STRETCH_TICKS = 8,
    parameter int         BLINK_TICKS   = 16,
    parameter int         ACTIVE_LOW    = 0,
    parameter logic [2:0] DEFAULT_MODE  = 3'd4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [N_CH-1:0] status_in,
    input  logic [N_CH-1:0] event_in,
    input  logic            cfg_we,
    input  logic [3:0]      cfg_addr,
    input  logic [7:0]      cfg_wdata,
    output logic [7:0]      cfg_rdata,
    output logic            tick,
    output logic [N_CH-1:0] led
);

    // Channel modes; 6 and 7 decode as OFF.
    localparam logic [2:0] MODE_OFF      = 3'd0;
    localparam logic [2:0] MODE_ON       = 3'd1;
    localparam logic [2:0] MODE_LEVEL    = 3'd2;
    localparam logic [2:0] MODE_ACTIVITY = 3'd3;
    localparam logic [2:0] MODE_HB       = 3'd4;
    localparam logic [2:0] MODE_BLINK    = 3'd5;

    // Blink FSM states.
    localparam logic [1:0] ST_ON  = 2'd0;
    localparam logic [1:0] ST_OFF = 2'd1;
    localparam logic [1:0] ST_GAP = 2'd2;

    // The phase counter must hold the longest phase (GAP = 4*BLINK_TICKS).
    localparam int              PH_W     = $clog2(4 * BLINK_TICKS);
    localparam logic [PH_W-1:0] ON_LAST  = PH_W'(BLINK_TICKS - 1);
    localparam logic [PH_W-1:0] GAP_LAST = PH_W'(4 * BLINK_TICKS - 1);
    localparam logic [7:0]      STRETCH_LOAD = 8'(STRETCH_TICKS);

    localparam logic [N_CH-1:0] LED_OFF = (ACTIVE_LOW != 0) ? '1 : '0;

    // -----------------------------------------------------------------------
    // Shared prescaler and tick counter
    // -----------------------------------------------------------------------
    logic [PRESC_W-1:0] presc_q;
    logic [7:0]         tick_cnt;

    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge values of its neighbours, regardless of the
    // order the always blocks are evaluated in.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            presc_q  <= '0;
            tick_cnt <= '0;
        end else begin
            presc_q <= presc_q + PRESC_W'(1);
            if (tick) begin
                tick_cnt <= tick_cnt + 8'd1;
            end
        end
    end

    // Decoded from the counter register, so it is high for exactly the one
    // cycle in which the counter is all-ones and low while in reset.
    assign tick = &presc_q;

    // Heartbeat is common to all channels, which keeps them phase-aligned.
    logic hb_level;
    assign hb_level = tick_cnt[HB_SEL];

    // -----------------------------------------------------------------------
    // Per-channel state
    // -----------------------------------------------------------------------
    logic [N_CH-1:0] led_next;
    logic [7:0]      rd_word [N_CH];

    for (genvar g = 0; g < N_CH; g++) begin : g_ch
        logic            wr_sel;
        logic [2:0]      mode_q;
        logic [3:0]      count_q;
        logic [7:0]      stretch_q;
        logic [1:0]      state_q;
        logic [PH_W-1:0] phase_q;
        logic [3:0]      flash_q;
        logic            led_raw;

        // Out-of-range addresses never match any channel, so such writes
        // fall through without effect.
        assign wr_sel = cfg_we && (cfg_addr == 4'(g));

        // NOTE: the mode/count registers are reset explicitly; they form a
        // small register file, not a RAM, and the board must come up in a
        // known LED pattern before software touches it.
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                mode_q  <= DEFAULT_MODE;
                count_q <= '0;
            end else if (wr_sel) begin
                mode_q  <= cfg_wdata[2:0];
                count_q <= cfg_wdata[6:3];
            end
        end

        assign rd_word[g] = {1'b0, count_q, mode_q};

        // Activity stretch counter: an event (re)loads the full hold time,
        // which wins over a tick in the same cycle; a config write clears it.
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                stretch_q <= '0;
            end else if (wr_sel) begin
                stretch_q <= '0;
            end else if (event_in[g]) begin
                stretch_q <= STRETCH_LOAD;
            end else if (tick && (stretch_q != 8'd0)) begin
                stretch_q <= stretch_q - 8'd1;
            end
        end

        // Blink FSM. Phases only advance on ticks, so the first phase after
        // a restart can be up to one tick short. A zero flash count parks
        // the FSM in GAP with the LED dark.
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                state_q <= ST_GAP;
                phase_q <= '0;
                flash_q <= '0;
            end else if (wr_sel) begin
                state_q <= (cfg_wdata[6:3] == 4'd0) ? ST_GAP : ST_ON;
                phase_q <= '0;
                flash_q <= '0;
            end else if (count_q == 4'd0) begin
                state_q <= ST_GAP;
                phase_q <= '0;
                flash_q <= '0;
            end else if (tick) begin
                case (state_q)
                    ST_ON: begin
                        if (phase_q == ON_LAST) begin
                            state_q <= ST_OFF;
                            phase_q <= '0;
                            flash_q <= flash_q + 4'd1;
                        end else begin
                            phase_q <= phase_q + PH_W'(1);
                        end
                    end
                    ST_OFF: begin
                        if (phase_q == ON_LAST) begin
                            state_q <= (flash_q < count_q) ? ST_ON : ST_GAP;
                            phase_q <= '0;
                        end else begin
                            phase_q <= phase_q + PH_W'(1);
                        end
                    end
                    ST_GAP: begin
                        if (phase_q == GAP_LAST) begin
                            state_q <= ST_ON;
                            phase_q <= '0;
                            flash_q <= '0;
                        end else begin
                            phase_q <= phase_q + PH_W'(1);
                        end
                    end
                    default: begin
                        state_q <= ST_GAP;
                        phase_q <= '0;
                        flash_q <= '0;
                    end
                endcase
            end
        end

        // Output select. Every channel keeps its stretch and blink state
        // running; the mode only decides which source reaches the pin.
        // NOTE: led_raw gets a default before the case so that no path
        // leaves it unassigned, which would infer a latch.
        always_comb begin
            led_raw = 1'b0;
            case (mode_q)
                MODE_OFF:      led_raw = 1'b0;
                MODE_ON:       led_raw = 1'b1;
                MODE_LEVEL:    led_raw = status_in[g];
                MODE_ACTIVITY: led_raw = (stretch_q != 8'd0) || event_in[g];
                MODE_HB:       led_raw = hb_level;
                MODE_BLINK:    led_raw = (state_q == ST_ON);
                default:       led_raw = 1'b0;
            endcase
        end

        assign led_next[g] = led_raw;
    end

    // -----------------------------------------------------------------------
    // Registered outputs
    // -----------------------------------------------------------------------
    logic [7:0] rd_next;

    always_comb begin
        rd_next = '0;
        for (int i = 0; i < N_CH; i++) begin
            if (cfg_addr == 4'(i)) begin
                rd_next = rd_word[i];
            end
        end
    end

    // Readback samples the registers before this edge's write lands, so a
    // write and read of the same channel in one cycle returns the old value.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cfg_rdata <= '0;
            led       <= LED_OFF;
        end else begin
            cfg_rdata <= rd_next;
            led       <= (ACTIVE_LOW != 0) ? ~led_next : led_next;
        end
    end

    // Reserved write bit, accepted and ignored.
    logic unused_wdata;
    assign unused_wdata = cfg_wdata[7];

endmodule

// File: tb/tb_status_led_ctl.sv
// ---------------------------------------------------------------------------
// tb_status_led_ctl
//
// Directed bench for status_led_ctl with a 4-clock tick (PRESC_W=2),
// 3-tick activity hold, 2-tick blink phases and heartbeat on tick_cnt[1].
// Two instances share all inputs: one active-high, one active-low.
// A free-running cycle counter, reset alongside the DUTs, gives the
// expected prescaler phase and heartbeat level.
// ---------------------------------------------------------------------------
module tb_status_led_ctl;

    localparam int N_CH = 3;

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic [N_CH-1:0] status_in = '0;
    logic [N_CH-1:0] event_in = '0;
    logic            cfg_we = 1'b0;
    logic [3:0]      cfg_addr = '0;
    logic [7:0]      cfg_wdata = '0;

    logic [7:0]      cfg_rdata, cfg_rdata_inv;
    logic            tick, tick_inv;
    logic [N_CH-1:0] led, led_inv;

    int checks = 0;
    int errors = 0;
    int cyc;

    status_led_ctl #(
        .N_CH(N_CH), .PRESC_W(2), .HB_SEL(1), .STRETCH_TICKS(3),
        .BLINK_TICKS(2), .ACTIVE_LOW(0), .DEFAULT_MODE(3'd4)
    ) dut (
        .clk(clk), .reset(reset), .status_in(status_in), .event_in(event_in),
        .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata),
        .cfg_rdata(cfg_rdata), .tick(tick), .led(led)
    );

    status_led_ctl #(
        .N_CH(N_CH), .PRESC_W(2), .HB_SEL(1), .STRETCH_TICKS(3),
        .BLINK_TICKS(2), .ACTIVE_LOW(1), .DEFAULT_MODE(3'd4)
    ) dut_inv (
        .clk(clk), .reset(reset), .status_in(status_in), .event_in(event_in),
        .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata),
        .cfg_rdata(cfg_rdata_inv), .tick(tick_inv), .led(led_inv)
    );

    always #5 clk = ~clk;

    // Number of rising edges since reset was released.
    always @(posedge clk or posedge reset) begin
        if (reset) cyc <= 0;
        else       cyc <= cyc + 1;
    end

    // tick_cnt = floor(m/4) after m edges; the LED shows bit 1 of it one
    // edge later, i.e. bit 3 of (m-1).
    function automatic logic hb_exp(input int m);
        logic [31:0] t;
        if (m < 1) return 1'b0;
        t = 32'(m - 1);
        return t[3];
    endfunction

    task automatic cfg_write(input logic [3:0] a, input logic [7:0] d);
        cfg_we    = 1'b1;
        cfg_addr  = a;
        cfg_wdata = d;
        @(negedge clk);
        cfg_we    = 1'b0;
    endtask

    // Advance to the negedge just before a tick edge (prescaler = 3).
    task automatic align_to_tick();
        for (int k = 0; k < 8; k++) begin
            if (cyc % 4 == 3) break;
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        checks++;
        if (led !== 3'b000 || led_inv !== 3'b111) begin
            errors++;
            $display("FAIL reset_led got=%b/%b exp=000/111", led, led_inv);
        end
        checks++;
        if (tick !== 1'b0 || tick_inv !== 1'b0) begin
            errors++;
            $display("FAIL reset_tick got=%b/%b exp=0/0", tick, tick_inv);
        end
        checks++;
        if (cfg_rdata !== 8'h00 || cfg_rdata_inv !== 8'h00) begin
            errors++;
            $display("FAIL reset_rdata got=%h/%h exp=00", cfg_rdata, cfg_rdata_inv);
        end
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            cfg_addr = 4'(i);
            @(negedge clk);
            checks++;
            if (cfg_rdata !== ((i < 3) ? 8'h04 : 8'h00) || cfg_rdata_inv !== cfg_rdata) begin
                errors++;
                $display("FAIL reset_read addr=%0d got=%h/%h exp=%h", i, cfg_rdata,
                         cfg_rdata_inv, (i < 3) ? 8'h04 : 8'h00);
            end
        end
        cfg_addr = '0;
    endtask

    task automatic test_heartbeat();
        logic e;
        for (int k = 0; k < 32; k++) begin
            @(negedge clk);
            e = hb_exp(cyc);
            checks++;
            if (led !== {3{e}} || led_inv !== ~{3{e}}) begin
                errors++;
                $display("FAIL heartbeat cyc=%0d got=%b/%b exp=%b/%b", cyc, led, led_inv,
                         {3{e}}, ~{3{e}});
            end
            checks++;
            if (tick !== (cyc % 4 == 3) || tick_inv !== tick) begin
                errors++;
                $display("FAIL tick cyc=%0d got=%b exp=%b", cyc, tick, (cyc % 4 == 3));
            end
        end
    endtask

    task automatic test_cfg();
        cfg_write(4'd3, 8'h1D);
        checks++;
        if (cfg_rdata !== 8'h00) begin
            errors++;
            $display("FAIL oob_read got=%h exp=00", cfg_rdata);
        end
        for (int i = 0; i < 3; i++) begin
            cfg_addr = 4'(i);
            @(negedge clk);
            checks++;
            if (cfg_rdata !== 8'h04) begin
                errors++;
                $display("FAIL oob_nochange addr=%0d got=%h exp=04", i, cfg_rdata);
            end
        end
        cfg_write(4'd1, 8'h0B);
        checks++;
        if (cfg_rdata !== 8'h04) begin
            errors++;
            $display("FAIL rw_same_old got=%h exp=04", cfg_rdata);
        end
        @(negedge clk);
        checks++;
        if (cfg_rdata !== 8'h0B) begin
            errors++;
            $display("FAIL rw_same_new got=%h exp=0b", cfg_rdata);
        end
    endtask

    task automatic test_modes();
        logic [5:0] pat = 6'b101101;
        cfg_write(4'd0, 8'h02);
        cfg_write(4'd1, 8'h01);
        cfg_write(4'd2, 8'h00);
        for (int k = 0; k < 6; k++) begin
            status_in = {~pat[k], pat[k], pat[k]};
            @(negedge clk);
            checks++;
            if (led !== {1'b0, 1'b1, pat[k]}) begin
                errors++;
                $display("FAIL modes_level step=%0d got=%b exp=%b", k, led,
                         {1'b0, 1'b1, pat[k]});
            end
        end
        status_in = 3'b111;
        event_in  = 3'b111;
        cfg_write(4'd1, 8'h06);
        cfg_write(4'd2, 8'h07);
        cfg_write(4'd0, 8'h00);
        @(negedge clk);
        checks++;
        if (led !== 3'b000) begin
            errors++;
            $display("FAIL modes_off got=%b exp=000", led);
        end
        status_in = '0;
        event_in  = '0;
    endtask

    task automatic test_activity();
        logic e;
        cfg_write(4'd1, 8'h03);
        @(negedge clk);
        // Single event coinciding with a tick edge: load wins.
        align_to_tick();
        for (int k = 0; k <= 14; k++) begin
            event_in[1] = (k == 0);
            @(negedge clk);
            e = (k <= 12);
            checks++;
            if (led[1] !== e) begin
                errors++;
                $display("FAIL act_single k=%0d got=%b exp=%b", k, led[1], e);
            end
        end
        // Event off-tick, retriggered one tick before expiry.
        align_to_tick();
        for (int k = 0; k <= 22; k++) begin
            event_in[1] = (k == 1) || (k == 9);
            @(negedge clk);
            e = (k >= 1) && (k <= 20);
            checks++;
            if (led[1] !== e) begin
                errors++;
                $display("FAIL act_retrig k=%0d got=%b exp=%b", k, led[1], e);
            end
        end
        event_in = '0;
    endtask

    task automatic test_blink();
        int  n_hi;
        bit  found;
        logic e;
        cfg_write(4'd0, 8'h1D);
        @(negedge clk);
        checks++;
        if (led[0] !== 1'b1) begin
            errors++;
            $display("FAIL blink_start got=%b exp=1", led[0]);
        end
        n_hi  = 1;
        found = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (led[0] === 1'b0) begin
                found = 1'b1;
                break;
            end
            n_hi++;
        end
        checks++;
        if (!found || n_hi < 5 || n_hi > 8) begin
            errors++;
            $display("FAIL blink_first found=%0d high_cycles=%0d exp=5..8", found, n_hi);
        end
        // s=0 is the first low sample; OFF/ON/OFF/ON/OFF+GAP/ON follow.
        for (int s = 1; s <= 80; s++) begin
            @(negedge clk);
            e = (s >= 8 && s < 16) || (s >= 24 && s < 32) || (s >= 72 && s < 80);
            checks++;
            if (led[0] !== e) begin
                errors++;
                $display("FAIL blink_pattern s=%0d got=%b exp=%b", s, led[0], e);
            end
        end
        // Rewriting identical data restarts the code at ON.
        cfg_write(4'd0, 8'h1D);
        @(negedge clk);
        checks++;
        if (led[0] !== 1'b1) begin
            errors++;
            $display("FAIL blink_restart got=%b exp=1", led[0]);
        end
        cfg_write(4'd0, 8'h05);
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            checks++;
            if (led[0] !== 1'b0) begin
                errors++;
                $display("FAIL blink_zero k=%0d got=%b exp=0", k, led[0]);
            end
        end
    endtask

    task automatic test_async_reset();
        cfg_write(4'd1, 8'h01);
        @(negedge clk);
        checks++;
        if (led[1] !== 1'b1 || led_inv[1] !== 1'b0) begin
            errors++;
            $display("FAIL pre_reset_on got=%b/%b exp=1/0", led[1], led_inv[1]);
        end
        @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        checks++;
        if (led !== 3'b000 || led_inv !== 3'b111 || tick !== 1'b0 || cfg_rdata !== 8'h00) begin
            errors++;
            $display("FAIL async_reset led=%b led_inv=%b tick=%b rdata=%h exp=000/111/0/00",
                     led, led_inv, tick, cfg_rdata);
        end
        @(negedge clk);
        reset    = 1'b0;
        cfg_addr = 4'd1;
        @(negedge clk);
        checks++;
        if (cfg_rdata !== 8'h04) begin
            errors++;
            $display("FAIL reset_mode got=%h exp=04", cfg_rdata);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_heartbeat();
        test_cfg();
        test_modes();
        test_activity();
        test_blink();
        test_async_reset();
        test_heartbeat();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
